// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and sequencer states.
// Ports: none (package only).
// Latency/backpressure: not applicable.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also serves MTHI/MTLO, HI/LO drive MFHI/MFLO.
// Ports: i_clk/i_reset, i_start/i_op/i_a/i_b launch, i_mthi/i_mtlo moves, o_hi/o_lo, o_busy, o_done/o_divz pulses.
// Latency: DATA_WIDTH+2 cycles start-to-done; o_busy stalls the pipe, start/moves ignored unless IDLE.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_mthi,
    input  logic                  i_mtlo,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_divz
);
    localparam int W = DATA_WIDTH;

    mdu_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;        // operand signs differ: flip product / quotient
    logic                 a_neg_q, a_neg_d;    // dividend negative: remainder takes its sign
    logic                 divz_q, divz_d;
    logic [W-1:0]         a_orig_q, a_orig_d;  // raw dividend, returned in HI on divide-by-zero
    logic [W-1:0]         mag_b_q, mag_b_d;    // multiplicand or divisor magnitude
    logic [W-1:0]         rem_q, rem_d;        // product high half / partial remainder
    logic [W-1:0]         quo_q, quo_d;        // multiplier shifting into product low / dividend->quotient
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, divz_o_q, divz_o_d;

    logic                 op_signed, op_div;
    logic [W-1:0]         a_abs, b_abs;
    logic [W:0]           add_x, add_y, add_res, mul_sum;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         quo_fix, rem_fix;

    always_comb begin
        op_signed = ~i_op[0];
        op_div    = i_op[1];
        a_abs     = (op_signed && i_a[W-1]) ? -i_a : i_a;
        b_abs     = (op_signed && i_b[W-1]) ? -i_b : i_b;

        // One W+1-bit adder serves both sequences: add for shift-add, subtract
        // (invert + carry-in) for the restoring trial subtraction.
        add_x   = is_div_q ? {rem_q, quo_q[W-1]} : {1'b0, rem_q};
        add_y   = {1'b0, mag_b_q};
        add_res = add_x + (is_div_q ? ~add_y : add_y) + {{W{1'b0}}, is_div_q};
        mul_sum = quo_q[0] ? add_res : add_x;

        prod    = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
        quo_fix = neg_q ? -quo_q : quo_q;
        rem_fix = a_neg_q ? -rem_q : rem_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        divz_d   = divz_q;
        a_orig_d = a_orig_q;
        mag_b_d  = mag_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        divz_o_d = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (i_start) begin
                    is_div_d = op_div;
                    neg_d    = op_signed & (i_a[W-1] ^ i_b[W-1]);
                    a_neg_d  = op_signed & i_a[W-1];
                    divz_d   = op_div & (i_b == '0);
                    a_orig_d = i_a;
                    rem_d    = '0;
                    quo_d    = op_div ? a_abs : b_abs;
                    mag_b_d  = op_div ? b_abs : a_abs;
                    cnt_d    = CNT_WIDTH'(W - 1);
                    state_d  = MDU_CALC;
                end else begin
                    if (i_mthi) hi_d = i_a;
                    if (i_mtlo) lo_d = i_a;
                end
            end
            MDU_CALC: begin
                if (is_div_q) begin
                    // add_res[W] set means the trial subtraction borrowed: restore.
                    if (add_res[W]) begin
                        rem_d = add_x[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end else begin
                        rem_d = add_res[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end
                end else begin
                    {rem_d, quo_d} = {mul_sum, quo_q[W-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (divz_q) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d   = 1'b1;
                divz_o_d = is_div_q & divz_q;
                state_d  = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            divz_q   <= 1'b0;
            a_orig_q <= '0;
            mag_b_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            divz_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            divz_q   <= divz_d;
            a_orig_q <= a_orig_d;
            mag_b_q  <= mag_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            divz_o_q <= divz_o_d;
        end
    end

    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
    assign o_busy = (state_q != MDU_IDLE);
    assign o_done = done_q;
    assign o_divz = divz_o_q;

endmodule
